// File: rtl/cache_ctrl.sv
// Cache controller: sequences compare, write-back and line-fill traffic between a CPU port,
// a single direct-mapped set array and a word-addressed backing memory.
module cache_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   // CPU side
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [9:0]  cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        busy,
   // Set array side
   output logic [2:0]  set_sel,
   output logic        set_enable,
   output logic [1:0]  set_word,
   output logic        set_cmp,
   output logic        set_write,
   output logic [4:0]  set_tag,
   output logic [15:0] set_data_in,
   output logic        set_valid_in,
   input  logic        set_hit,
   input  logic        set_dirty,
   input  logic        set_valid,
   input  logic        set_ack,
   input  logic [4:0]  set_tag_out,
   input  logic [15:0] set_data_out,
   // Memory side
   output logic        mem_req,
   output logic        mem_we,
   output logic [9:0]  mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {
      StIdle, StCmp, StWbRd, StWbMem, StAlMem, StAlWr, StDone
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  k_q, k_d;
   logic        we_q, we_d;
   logic [9:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [4:0]  wb_tag_q, wb_tag_d;
   logic [15:0] wb_data_q, wb_data_d;
   logic [15:0] fill_q, fill_d;
   logic [15:0] rdata_q, rdata_d;
   logic        gap_q, gap_d;

   logic [4:0]  req_tag;
   logic [2:0]  req_index;
   logic [1:0]  req_word;
   logic        set_go;
   logic        mem_go;

   assign req_tag   = addr_q[9:5];
   assign req_index = addr_q[4:2];
   assign req_word  = addr_q[1:0];

   // gap_q forces one low cycle after every accepted ack, so a request always drops
   // before the next one rises, even between back-to-back set or memory states.
   assign set_enable = ((state_q == StCmp) || (state_q == StWbRd) || (state_q == StAlWr))
                       && !gap_q;
   assign mem_req    = ((state_q == StWbMem) || (state_q == StAlMem)) && !gap_q;
   assign set_go     = set_enable & set_ack;
   assign mem_go     = mem_req & mem_ack;

   assign busy      = (state_q != StIdle);
   assign cpu_ready = (state_q == StDone);
   assign cpu_rdata = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         k_q       <= 2'd0;
         we_q      <= 1'b0;
         addr_q    <= 10'd0;
         wdata_q   <= 16'd0;
         wb_tag_q  <= 5'd0;
         wb_data_q <= 16'd0;
         fill_q    <= 16'd0;
         rdata_q   <= 16'd0;
         gap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wb_tag_q  <= wb_tag_d;
         wb_data_q <= wb_data_d;
         fill_q    <= fill_d;
         rdata_q   <= rdata_d;
         gap_q     <= gap_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wb_tag_d     = wb_tag_q;
      wb_data_d    = wb_data_q;
      fill_d       = fill_q;
      rdata_d      = rdata_q;
      gap_d        = 1'b0;
      set_sel      = 3'd0;
      set_word     = 2'd0;
      set_cmp      = 1'b0;
      set_write    = 1'b0;
      set_tag      = 5'd0;
      set_data_in  = 16'd0;
      set_valid_in = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = 10'd0;
      mem_wdata    = 16'd0;

      unique case (state_q)
         StIdle: begin
            if (cpu_req) begin
               we_d    = cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               state_d = StCmp;
            end
         end

         StCmp: begin
            set_sel     = req_index;
            set_word    = req_word;
            set_cmp     = 1'b1;
            set_write   = we_q;
            set_tag     = req_tag;
            set_data_in = wdata_q;
            if (set_go) begin
               gap_d = 1'b1;
               k_d   = 2'd0;
               if (set_hit && set_valid) begin
                  if (!we_q) rdata_d = set_data_out;
                  state_d = StDone;
               end else if (set_valid && set_dirty) begin
                  state_d = StWbRd;
               end else begin
                  state_d = StAlMem;
               end
            end
         end

         StWbRd: begin
            set_sel  = req_index;
            set_word = k_q;
            if (set_go) begin
               gap_d     = 1'b1;
               wb_tag_d  = set_tag_out;
               wb_data_d = set_data_out;
               state_d   = StWbMem;
            end
         end

         StWbMem: begin
            mem_we    = 1'b1;
            mem_addr  = {wb_tag_q, req_index, k_q};
            mem_wdata = wb_data_q;
            if (mem_go) begin
               gap_d = 1'b1;
               if (k_q == 2'd3) begin
                  k_d     = 2'd0;
                  state_d = StAlMem;
               end else begin
                  k_d     = k_q + 2'd1;
                  state_d = StWbRd;
               end
            end
         end

         StAlMem: begin
            mem_addr = {req_tag, req_index, k_q};
            if (mem_go) begin
               gap_d   = 1'b1;
               fill_d  = mem_rdata;
               state_d = StAlWr;
            end
         end

         StAlWr: begin
            set_sel      = req_index;
            set_word     = k_q;
            set_write    = 1'b1;
            set_tag      = req_tag;
            set_data_in  = fill_q;
            set_valid_in = 1'b1;
            if (set_go) begin
               gap_d = 1'b1;
               if (k_q == 2'd3) begin
                  // Line fully refilled: retry the original compare, which now hits.
                  k_d     = 2'd0;
                  state_d = StCmp;
               end else begin
                  k_d     = k_q + 2'd1;
                  state_d = StAlMem;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural set array and memory with programmable ack latency,
// a table of directed transactions and hand-written reset / held-request / spurious-ack cases.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we;
   logic [9:0]  cpu_addr;
   logic [15:0] cpu_wdata, cpu_rdata;
   logic        cpu_ready, busy;
   logic [2:0]  set_sel;
   logic        set_enable, set_cmp, set_write, set_valid_in;
   logic [1:0]  set_word;
   logic [4:0]  set_tag, set_tag_out;
   logic [15:0] set_data_in, set_data_out;
   logic        set_hit, set_dirty, set_valid, set_ack;
   logic        mem_req, mem_we, mem_ack;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy),
      .set_sel(set_sel), .set_enable(set_enable), .set_word(set_word), .set_cmp(set_cmp),
      .set_write(set_write), .set_tag(set_tag), .set_data_in(set_data_in),
      .set_valid_in(set_valid_in), .set_hit(set_hit), .set_dirty(set_dirty),
      .set_valid(set_valid), .set_ack(set_ack), .set_tag_out(set_tag_out),
      .set_data_out(set_data_out),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   // ---------------- set array and memory models ----------------
   logic        lv [8];
   logic        ld [8];
   logic [4:0]  lt [8];
   logic [15:0] ldat [8][4];
   logic [15:0] mem [1024];
   int          sd, md, set_cnt, mem_cnt, setup_code;
   logic        setup_go, spur_set, spur_mem;

   assign set_ack   = (set_enable && (set_cnt >= sd)) || spur_set;
   assign mem_ack   = (mem_req && (mem_cnt >= md)) || spur_mem;
   assign mem_rdata = mem[mem_addr];

   always_comb begin
      set_hit      = (lt[set_sel] == set_tag);
      set_valid    = lv[set_sel];
      set_dirty    = ld[set_sel];
      set_tag_out  = lt[set_sel];
      set_data_out = ldat[set_sel][set_word];
   end

   always @(posedge clk) begin
      if (!rst_n)                       set_cnt <= 0;
      else if (set_enable && set_ack)   set_cnt <= 0;
      else if (set_enable)              set_cnt <= set_cnt + 1;
      if (!rst_n)                       mem_cnt <= 0;
      else if (mem_req && mem_ack)      mem_cnt <= 0;
      else if (mem_req)                 mem_cnt <= mem_cnt + 1;
   end

   always @(posedge clk) begin
      if (setup_go) begin
         case (setup_code)
            0: begin
               for (int i = 0; i < 8; i++) begin
                  lv[i] <= 1'b0; ld[i] <= 1'b0; lt[i] <= 5'd0;
                  for (int w = 0; w < 4; w++) ldat[i][w] <= 16'd0;
               end
               for (int a = 0; a < 1024; a++) mem[a] <= 16'd0;
            end
            1: begin
               lv[0] <= 1'b1; ld[0] <= 1'b0; lt[0] <= 5'b11101;
               for (int w = 0; w < 3; w++) ldat[0][w] <= 16'h0A00 + 16'(w);
               ldat[0][3] <= 16'h0F0F;
            end
            2: begin
               lv[2] <= 1'b0; ld[2] <= 1'b0;
               for (int w = 0; w < 4; w++) mem[{5'b00001, 3'b010, 2'(w)}] <= 16'h1000 + 16'(w);
            end
            3: begin
               lv[2] <= 1'b1; ld[2] <= 1'b1; lt[2] <= 5'b00111;
               for (int w = 0; w < 4; w++) begin
                  ldat[2][w] <= 16'hA000 + 16'(w);
                  mem[{5'b01000, 3'b010, 2'(w)}] <= 16'h2000 + 16'(w);
               end
            end
            default: ;
         endcase
      end else if (set_enable && set_ack) begin
         if (set_cmp) begin
            if (set_write && lv[set_sel] && (lt[set_sel] == set_tag)) begin
               ldat[set_sel][set_word] <= set_data_in;
               ld[set_sel] <= 1'b1;
            end
         end else if (set_write) begin
            ldat[set_sel][set_word] <= set_data_in;
            lt[set_sel] <= set_tag;
            lv[set_sel] <= set_valid_in;
            ld[set_sel] <= 1'b0;
         end
      end
      if (!setup_go && mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
   end

   // ---------------- protocol monitor ----------------
   int          n_set, n_rd, n_wr, n_ready, n_start, n_viol;
   logic        last_dirty;
   logic [9:0]  rd_log [16];
   logic [9:0]  wr_log [16];
   logic [15:0] wd_log [16];
   logic        set_pend, mem_pend, set_acc, mem_acc, ready_prev, busy_prev;
   logic [31:0] set_bus, set_bus_prev;
   logic [26:0] mem_bus, mem_bus_prev;

   assign set_bus = {set_sel, set_word, set_cmp, set_write, set_tag, set_data_in, set_valid_in};
   assign mem_bus = {mem_we, mem_addr, mem_wdata};

   always @(posedge clk) begin
      if (setup_go) begin
         n_set <= 0; n_rd <= 0; n_wr <= 0; n_ready <= 0; n_start <= 0; n_viol <= 0;
         last_dirty <= 1'b0;
      end else begin
         if (set_enable && set_ack) begin
            n_set <= n_set + 1;
            if (set_cmp) last_dirty <= set_dirty;
         end
         if (mem_req && mem_ack) begin
            if (mem_we) begin
               if (n_wr < 16) begin
                  wr_log[n_wr] <= mem_addr;
                  wd_log[n_wr] <= mem_wdata;
               end
               n_wr <= n_wr + 1;
            end else begin
               if (n_rd < 16) rd_log[n_rd] <= mem_addr;
               n_rd <= n_rd + 1;
            end
         end
         if (cpu_ready) n_ready <= n_ready + 1;
         if (busy && !busy_prev) n_start <= n_start + 1;
         n_viol <= n_viol + int'(set_enable && mem_req)
                  + int'(set_enable && set_pend && (set_bus != set_bus_prev))
                  + int'(mem_req && mem_pend && (mem_bus != mem_bus_prev))
                  + int'(set_enable && set_acc) + int'(mem_req && mem_acc)
                  + int'(cpu_ready && ready_prev);
      end
      set_pend     <= set_enable && !set_ack;
      mem_pend     <= mem_req && !mem_ack;
      set_acc      <= set_enable && set_ack;
      mem_acc      <= mem_req && mem_ack;
      set_bus_prev <= set_bus;
      mem_bus_prev <= mem_bus;
      ready_prev   <= cpu_ready;
      busy_prev    <= busy;
   end

   // ---------------- checking helpers ----------------
   int n_cmp = 0;
   int n_bad = 0;

   logic [75:0] all_out;
   assign all_out = {cpu_rdata, cpu_ready, busy, set_sel, set_enable, set_word, set_cmp,
                     set_write, set_tag, set_data_in, set_valid_in, mem_req, mem_we, mem_addr,
                     mem_wdata};

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_setup(input int code);
      setup_code = code;
      setup_go   = 1'b1;
      @(posedge clk); #1;
      setup_go   = 1'b0;
   endtask

   task automatic run_txn(input bit we, input logic [9:0] addr, input logic [15:0] wd,
                          input string nm, output logic [15:0] rd);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'd0; cpu_wdata = 16'd0;
      for (int i = 0; i < 2000 && !cpu_ready; i++) begin
         @(posedge clk); #1;
      end
      chk({nm, " ready"}, 80'(cpu_ready), 80'd1);
      rd = cpu_rdata;
      @(posedge clk); #1;
   endtask

   typedef struct {
      string       name;
      int          setup;
      int          sd;
      int          md;
      bit          we;
      logic [9:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      int          exp_set;
      int          exp_rd;
      int          exp_wr;
      logic [9:0]  rd_base;
      logic [9:0]  wr_base;
      logic        exp_dirty;
   } vec_t;

   vec_t        vecs [8];
   logic [15:0] rd;

   initial begin
      vecs[0] = '{"read_hit", 1, 0, 0, 1'b0, {5'b11101, 3'b000, 2'b11}, 16'h0, 16'h0F0F,
                  1, 0, 0, 10'h0, 10'h0, 1'b0};
      vecs[1] = '{"clean_read_miss", 2, 0, 0, 1'b0, {5'b00001, 3'b010, 2'b01}, 16'h0, 16'h1001,
                  6, 4, 0, {5'b00001, 3'b010, 2'b00}, 10'h0, 1'b0};
      vecs[2] = '{"dirty_write_miss", 3, 0, 0, 1'b1, {5'b01000, 3'b010, 2'b10}, 16'hBEEF,
                  16'h1001, 10, 4, 4, {5'b01000, 3'b010, 2'b00}, {5'b00111, 3'b010, 2'b00},
                  1'b0};
      vecs[3] = '{"read_after_write", 4, 1, 1, 1'b0, {5'b01000, 3'b010, 2'b10}, 16'h0, 16'hBEEF,
                  1, 0, 0, 10'h0, 10'h0, 1'b1};
      vecs[4] = '{"miss_ack1", 2, 1, 1, 1'b0, {5'b00001, 3'b010, 2'b11}, 16'h0, 16'h1003,
                  6, 4, 0, {5'b00001, 3'b010, 2'b00}, 10'h0, 1'b0};
      vecs[5] = '{"dirty_miss_ack5", 3, 5, 5, 1'b0, {5'b01000, 3'b010, 2'b00}, 16'h0, 16'h2000,
                  10, 4, 4, {5'b01000, 3'b010, 2'b00}, {5'b00111, 3'b010, 2'b00}, 1'b0};
      vecs[6] = '{"write_hit", 4, 0, 1, 1'b1, {5'b01000, 3'b010, 2'b00}, 16'h1234, 16'h2000,
                  1, 0, 0, 10'h0, 10'h0, 1'b0};
      vecs[7] = '{"read_dirty_hit", 4, 5, 0, 1'b0, {5'b01000, 3'b010, 2'b00}, 16'h0, 16'h1234,
                  1, 0, 0, 10'h0, 10'h0, 1'b1};

      rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'd0; cpu_wdata = 16'd0;
      setup_go = 1'b0; setup_code = 0; spur_set = 1'b0; spur_mem = 1'b0; sd = 0; md = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset outputs", 80'(all_out), 80'd0);
      do_setup(0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle after reset busy", 80'(busy), 80'd0);

      for (int v = 0; v < 8; v++) begin
         sd = vecs[v].sd;
         md = vecs[v].md;
         do_setup(vecs[v].setup);
         run_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].name, rd);
         chk({vecs[v].name, " rdata"}, 80'(rd), 80'(vecs[v].exp_rdata));
         chk({vecs[v].name, " set ops"}, 80'(n_set), 80'(vecs[v].exp_set));
         chk({vecs[v].name, " mem reads"}, 80'(n_rd), 80'(vecs[v].exp_rd));
         chk({vecs[v].name, " mem writes"}, 80'(n_wr), 80'(vecs[v].exp_wr));
         chk({vecs[v].name, " cmp dirty"}, 80'(last_dirty), 80'(vecs[v].exp_dirty));
         chk({vecs[v].name, " ready pulses"}, 80'(n_ready), 80'd1);
         chk({vecs[v].name, " protocol"}, 80'(n_viol), 80'd0);
         chk({vecs[v].name, " idle busy"}, 80'(busy), 80'd0);
         for (int k = 0; k < vecs[v].exp_rd && k < 16; k++)
            chk({vecs[v].name, " rd addr"}, 80'(rd_log[k]), 80'(vecs[v].rd_base + 10'(k)));
         for (int k = 0; k < vecs[v].exp_wr && k < 16; k++) begin
            chk({vecs[v].name, " wr addr"}, 80'(wr_log[k]), 80'(vecs[v].wr_base + 10'(k)));
            chk({vecs[v].name, " wr data"}, 80'(wd_log[k]), 80'(16'hA000 + 16'(k)));
         end
      end

      // Reset while writing back word 2 of a dirty line.
      sd = 0; md = 3;
      do_setup(3);
      cpu_we = 1'b1; cpu_addr = {5'b01000, 3'b010, 2'b10}; cpu_wdata = 16'hBEEF; cpu_req = 1'b1;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      for (int i = 0; i < 500 && !(mem_req && mem_we && mem_addr[1:0] == 2'd2); i++) begin
         @(posedge clk); #1;
      end
      chk("rst reach wb k2", 80'({mem_req, mem_we, mem_addr}), 80'({2'b11, 5'b00111, 3'b010,
          2'b10}));
      rst_n = 1'b0;
      #1;
      chk("rst outputs zero", 80'(all_out), 80'd0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rst not resumed busy", 80'(busy), 80'd0);
      chk("rst no ready", 80'(n_ready), 80'd0);
      chk("rst no mem req", 80'(mem_req), 80'd0);
      md = 0;
      do_setup(1);
      run_txn(1'b0, {5'b11101, 3'b000, 2'b11}, 16'h0, "post_rst_hit", rd);
      chk("post_rst_hit rdata", 80'(rd), 80'h0F0F);
      chk("post_rst_hit set ops", 80'(n_set), 80'd1);
      chk("post_rst_hit mem reads", 80'(n_rd), 80'd0);

      // Spurious acks while idle.
      do_setup(4);
      spur_set = 1'b1; spur_mem = 1'b1;
      @(posedge clk); #1;
      spur_set = 1'b0; spur_mem = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("spurious busy", 80'(busy), 80'd0);
      chk("spurious ready", 80'(n_ready), 80'd0);
      chk("spurious rdata", 80'(cpu_rdata), 80'h0F0F);

      // cpu_req held high across a miss and the following hit.
      do_setup(2);
      cpu_we = 1'b0; cpu_addr = {5'b00001, 3'b010, 2'b10}; cpu_req = 1'b1;
      for (int i = 0; i < 1000 && n_ready < 2; i++) begin
         @(posedge clk); #1;
      end
      cpu_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("held ready pulses", 80'(n_ready), 80'd2);
      chk("held acceptances", 80'(n_start), 80'd2);
      chk("held mem reads", 80'(n_rd), 80'd4);
      chk("held set ops", 80'(n_set), 80'd7);
      chk("held rdata", 80'(cpu_rdata), 80'h1002);
      chk("held protocol", 80'(n_viol), 80'd0);
      chk("held idle busy", 80'(busy), 80'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
